// File: rtl/ifu_pkg.sv
// IFU shared types and sizing for the fetch buffer.
package ifu_pkg;

  localparam int FB_DEPTH = 4;
  localparam int FB_BYTES = 16;
  localparam int FB_HW    = FB_BYTES / 2;
  localparam int PTR_W    = $clog2(FB_DEPTH);
  localparam int CNT_W    = PTR_W + 1;

  typedef struct packed {
    logic [FB_BYTES*8-1:0] data;
    logic [63:1]           pc;
    logic [FB_HW-1:0]      hw_vld;
    logic                  fault;
  } fb_entry_t;

endpackage

// File: rtl/ifu_fb_hwmask.sv
// Valid-halfword mask from block start offset and taken-branch end.
module ifu_fb_hwmask
  import ifu_pkg::*;
(
  input  logic [2:0]       start,
  input  logic             kill,
  input  logic [2:0]       pos,
  output logic [FB_HW-1:0] mask,
  output logic             bad
);

  always_comb begin
    mask = '0;
    for (int i = 0; i < FB_HW; i++) begin
      mask[i] = (3'(i) >= start) & (~kill | (3'(i) <= pos));
    end
  end

  // A branch ending before the fetch start cannot be in this block.
  assign bad = kill & (pos < start);

endmodule

// File: rtl/ifu_fb_ctl.sv
// Fetch buffer: circular queue of F2 hit blocks feeding the aligner.
module ifu_fb_ctl
  import ifu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_l,
  input  logic               exu_flush_final,
  input  logic               ifc_fetch_req_f2,
  input  logic               ic_hit_f2,
  input  logic               ic_access_fault_f2,
  input  logic [63:1]        ifc_fetch_addr_f2,
  input  logic [127:0]       ic_rd_data_f2,
  input  logic               ifu_bp_kill_next_f2,
  input  logic [2:0]         ifu_bp_pos_f2,
  input  logic               aln_pop1,
  input  logic               aln_pop2,
  output logic               fb0_valid,
  output logic               fb1_valid,
  output logic [127:0]       fb0_data,
  output logic [127:0]       fb1_data,
  output logic [63:1]        fb0_pc,
  output logic [63:1]        fb1_pc,
  output logic [FB_HW-1:0]   fb0_hw_vld,
  output logic [FB_HW-1:0]   fb1_hw_vld,
  output logic               fb0_fault,
  output logic               fb1_fault,
  output logic               ifu_fb_consume1,
  output logic               ifu_fb_consume2,
  output logic [CNT_W-1:0]   fb_count,
  output logic               fb_err
);

  fb_entry_t ent_q [FB_DEPTH];
  fb_entry_t e0, e1, new_ent;

  logic [FB_DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0]    rd_ptr, wr_ptr, rd_ptr1;
  logic [PTR_W-1:0]    rd_d, wr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, npop, cnt_pop;
  logic                err_d;
  logic                push_req, push_ok, bad;
  logic                eff_pop1, eff_pop2, err_now;
  logic [FB_HW-1:0]    mask;

  ifu_fb_hwmask u_hwmask (
    .start (ifc_fetch_addr_f2[3:1]),
    .kill  (ifu_bp_kill_next_f2),
    .pos   (ifu_bp_pos_f2),
    .mask  (mask),
    .bad   (bad)
  );

  assign rd_ptr1   = rd_ptr + PTR_W'(1);
  assign e0        = ent_q[rd_ptr];
  assign e1        = ent_q[rd_ptr1];
  assign fb0_valid = valid_q[rd_ptr];
  assign fb1_valid = valid_q[rd_ptr1];

  assign eff_pop2 = aln_pop2 & fb1_valid;
  assign eff_pop1 = (aln_pop1 | (aln_pop2 & ~fb1_valid))
                  & fb0_valid & ~eff_pop2;

  assign ifu_fb_consume1 = eff_pop1 & ~exu_flush_final;
  assign ifu_fb_consume2 = eff_pop2 & ~exu_flush_final;

  always_comb begin
    npop = '0;
    unique case (1'b1)
      eff_pop2: npop = CNT_W'(2);
      eff_pop1: npop = CNT_W'(1);
      default:  npop = '0;
    endcase
  end

  // Pop is applied before the full check, so a full buffer
  // draining one entry can still take the new block.
  assign cnt_pop  = cnt_q - npop;
  assign push_req = ifc_fetch_req_f2 & ic_hit_f2 & ~exu_flush_final;
  assign push_ok  = push_req & ~bad
                  & (cnt_pop != CNT_W'(FB_DEPTH));

  assign err_now = ~exu_flush_final & (
                     (push_req & ~push_ok)
                   | (aln_pop1 & aln_pop2)
                   | (aln_pop1 & ~fb0_valid)
                   | (aln_pop2 & ~fb1_valid));

  assign new_ent.data   = ic_rd_data_f2;
  assign new_ent.pc     = {ifc_fetch_addr_f2[63:4], 3'b000};
  assign new_ent.hw_vld = mask;
  assign new_ent.fault  = ic_access_fault_f2;

  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_ptr;
    wr_d    = wr_ptr;
    cnt_d   = cnt_q;
    err_d   = fb_err | err_now;
    if (exu_flush_final) begin
      valid_d = '0;
      rd_d    = '0;
      wr_d    = '0;
      cnt_d   = '0;
    end else begin
      if (eff_pop1 | eff_pop2) valid_d[rd_ptr]  = 1'b0;
      if (eff_pop2)            valid_d[rd_ptr1] = 1'b0;
      if (push_ok) begin
        valid_d[wr_ptr] = 1'b1;
        wr_d            = wr_ptr + PTR_W'(1);
      end
      rd_d  = rd_ptr + npop[PTR_W-1:0];
      cnt_d = cnt_pop + CNT_W'(push_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      valid_q <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      cnt_q   <= '0;
      fb_err  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      rd_ptr  <= rd_d;
      wr_ptr  <= wr_d;
      cnt_q   <= cnt_d;
      fb_err  <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) ent_q[wr_ptr] <= new_ent;
  end

  assign fb_count   = cnt_q;
  assign fb0_data   = e0.data   & {128{fb0_valid}};
  assign fb1_data   = e1.data   & {128{fb1_valid}};
  assign fb0_pc     = e0.pc     & {63{fb0_valid}};
  assign fb1_pc     = e1.pc     & {63{fb1_valid}};
  assign fb0_hw_vld = e0.hw_vld & {FB_HW{fb0_valid}};
  assign fb1_hw_vld = e1.hw_vld & {FB_HW{fb1_valid}};
  assign fb0_fault  = e0.fault  & fb0_valid;
  assign fb1_fault  = e1.fault  & fb1_valid;

endmodule

// File: doc/ifu_fb_ctl.md
Name: ifu_fb_ctl

Overview:
- Fetch buffer directly downstream of the fetch control stage.
- Captures 16-byte F2 I-cache hit blocks into a 4-entry circular queue and presents the two oldest entries (fb0, fb1) to the aligner.
- Retires entries on aligner pops and drives ifu_fb_consume1/ifu_fb_consume2 back to fetch control, which uses them for fetch-buffer mass balancing.

Parameters:
- FB_DEPTH, 4, number of entries; power of 2, at least 2; pointer width is log2(FB_DEPTH).
- FB_BYTES, 16, bytes per fetch block; halfwords per entry HW = FB_BYTES/2 = 8.

Ports:
- clk  in  1  core clock
- rst_l  in  1  synchronous active-low reset
- exu_flush_final  in  1  pipeline flush
- ifc_fetch_req_f2  in  1  F2 fetch valid
- ic_hit_f2  in  1  F2 I-cache/ICCM hit
- ic_access_fault_f2  in  1  F2 fetch access fault
- ifc_fetch_addr_f2  in  63  F2 fetch address [63:1]
- ic_rd_data_f2  in  128  F2 fetch data
- ifu_bp_kill_next_f2  in  1  taken branch predicted in this block
- ifu_bp_pos_f2  in  3  halfword index of the taken-branch end (valid with kill)
- aln_pop1  in  1  aligner finished fb0
- aln_pop2  in  1  aligner finished fb0 and fb1
- fb0_valid, fb1_valid  out  1 each
- fb0_data, fb1_data  out  128 each
- fb0_pc, fb1_pc  out  63 each  block base address [63:1], with [3:1] = 0
- fb0_hw_vld, fb1_hw_vld  out  8 each  valid-halfword mask
- fb0_fault, fb1_fault  out  1 each  access fault
- ifu_fb_consume1  out  1
- ifu_fb_consume2  out  1
- fb_count  out  3  occupied entries
- fb_err  out  1  sticky protocol error

Behaviour:
- Reset (rst_l=0 at posedge):
  - all entry valids, rd_ptr, wr_ptr, fb_count and fb_err go to 0.
  - Data, pc and mask registers are not reset.
  - All fbN_* outputs are AND-gated with fbN_valid, so every output reads 0 after reset.
- Push: push = ifc_fetch_req_f2 & ic_hit_f2 & ~exu_flush_final.
  - The entry is written at wr_ptr on the next edge.
  - Stored pc = {ifc_fetch_addr_f2[63:4], 3'b0}.
  - Mask bit i = (i >= addr[3:1]) & (~ifu_bp_kill_next_f2 | i <= ifu_bp_pos_f2).
  - If ifu_bp_pos_f2 < addr[3:1] while kill is set: push is dropped and fb_err is set.
  - A faulting hit stores its data with fault=1.
- Pop:
  - eff_pop2 = aln_pop2 & fb1_valid.
  - eff_pop1 = (aln_pop1 | (aln_pop2 & ~fb1_valid)) & fb0_valid & ~eff_pop2.
  - Popped entries are invalidated and rd_ptr advances by 1 or 2, modulo FB_DEPTH.
- Consume outputs (combinational, same cycle):
  - ifu_fb_consume1 = eff_pop1 & ~exu_flush_final.
  - ifu_fb_consume2 = eff_pop2 & ~exu_flush_final.
  - The two are mutually exclusive.
- Push and pop in the same cycle: pop applies first, so a full buffer popping 1 accepts the push. fb_count_next = count - pops + push.
- Full (count == FB_DEPTH) with push and no pop: push dropped, fb_err set. Entries are unchanged.
- Other protocol errors that set fb_err:
  - aln_pop1 & aln_pop2 together: treated as pop2.
  - Any pop beyond the valid entries: only valid entries are popped.
- Flush: when exu_flush_final=1,
  - next cycle all valids = 0, rd_ptr = wr_ptr = 0, count = 0;
  - the push and pops of that cycle are ignored.
- fb_err: sticky; cleared only by reset.
- Pointer wrap-around is modulo FB_DEPTH. Empty vs full is decided by fb_count, not by pointer compare.
- Latency: an F2 hit at edge N appears as fb0 (if empty) from cycle N+1. There is no bypass.

Decomposition:
- Package ifu_pkg:
  - typedef fb_entry_t {data[127:0], pc[63:1], hw_vld[7:0], fault};
  - constants FB_DEPTH, FB_HW = 8.
- Sub-module ifu_fb_hwmask: combinational start/end halfword mask generator (addr[3:1], kill, pos -> mask[7:0], bad). It is reused by the aligner.

Test Plan:
- Reset, then a hit push at addr 0x1004 (addr[3:1]=2), no kill -> next cycle fb0_valid=1, fb0_pc=0x1000>>1 field, fb0_hw_vld=8'b1111_1100, fb_count=1.
- Hit at 0x2000 with kill, pos=5 -> fb0_hw_vld=8'b0011_1111. Then with pos=1 at addr[3:1]=3 -> push dropped, fb_err=1.
- Four pushes without pop, fifth push -> count stays 4, fb_err=1. Then a fifth push together with aln_pop1 -> consume1=1 same cycle, count stays 4, the new block becomes the youngest entry.
- Three entries, aln_pop2 -> ifu_fb_consume2=1 same cycle, next cycle count=1, fb0 = the former third entry. Repeat over 3 wraps to check pointer wrap.
- Two entries plus a push, with exu_flush_final=1 and aln_pop1=1 -> consume1=0, next cycle count=0, all valids 0, outputs 0.
- Single entry, aln_pop2 -> consume1=1, consume2=0, fb_err=1, count=0. Assert rst_l=0 mid-stream -> all outputs 0 and fb_err=0 next cycle.
